// File: rtl/otter_mem_stage_ctrl.sv
// OTTER memory-stage access controller: multi-cycle data-memory loads, store lane steering,
// load alignment/extension, IO decode, misalignment flagging. Optional MEM_PERF_CNT_EN adds stall/load counters.
module otter_mem_stage_ctrl #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned LATENCY = 2,
  parameter logic [31:0] IO_BASE = 32'h1100_0000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       io_addr,
  output logic [31:0]       io_wdata,
  output logic              io_wr,
  input  logic [31:0]       io_in
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_ld_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        rsp_q;

  logic        misalign;
  logic        is_io;
  logic        accept;
  logic [31:0] load_src;
  logic [31:0] load_val;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] wdata_lanes;
  logic [3:0]  be_lanes;

  always_comb begin
    misalign = 1'b0;
    case (req_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = (req_addr[1:0] != 2'b00);
      default: misalign = 1'b1;
    endcase
  end

  assign is_io  = (req_addr >= IO_BASE);
  // Strobes are gated by RST_N so a request held through reset cannot reach memory or IO.
  assign accept = (state == IDLE) && req_valid && RST_N;
  assign mem_re = accept && !misalign && !is_io && !req_write;
  assign mem_we = accept && !misalign && !is_io && req_write;
  assign io_wr  = accept && !misalign && is_io && req_write;
  assign stall  = ((state == IDLE) && req_valid) || (state == BUSY);

  assign mem_addr  = req_addr[ADDR_W+1:2];
  assign io_addr   = req_addr;
  assign io_wdata  = req_wdata;
  assign mem_wdata = wdata_lanes;
  assign mem_be    = mem_we ? be_lanes : '0;

  always_comb begin
    wdata_lanes = req_wdata;
    be_lanes    = 4'b1111;
    case (req_size)
      2'b00: begin
        wdata_lanes = {4{req_wdata[7:0]}};
        be_lanes    = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        wdata_lanes = {2{req_wdata[15:0]}};
        be_lanes    = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_lanes = req_wdata;
        be_lanes    = 4'b1111;
      end
    endcase
  end

  // One aligner serves both sources: IO data is taken in IDLE, memory data at the end of BUSY.
  assign load_src = (state == BUSY) ? mem_rdata : io_in;

  always_comb begin
    byte_sel = load_src[7:0];
    case (req_addr[1:0])
      2'b00: byte_sel = load_src[7:0];
      2'b01: byte_sel = load_src[15:8];
      2'b10: byte_sel = load_src[23:16];
      2'b11: byte_sel = load_src[31:24];
      default: byte_sel = load_src[7:0];
    endcase
    half_sel = req_addr[1] ? load_src[31:16] : load_src[15:0];
    case (req_size)
      2'b00:   load_val = {{24{~req_unsigned & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{~req_unsigned & half_sel[15]}}, half_sel};
      default: load_val = load_src;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rsp_q   <= 1'b0;
    end else begin
      rsp_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (misalign) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              rsp_q   <= 1'b1;
              state   <= RESP;
            end else if (is_io || req_write) begin
              rdata_q <= (is_io && !req_write) ? load_val : '0;
              rsp_q   <= 1'b1;
              state   <= RESP;
            end else begin
              cnt   <= CNT_INIT;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            rdata_q <= load_val;
            rsp_q   <= 1'b1;
            state   <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          rdata_q <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid    = rsp_q;
  assign rsp_rdata    = rdata_q;
  assign misalign_err = err_q;

`ifdef MEM_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      perf_stall_cnt <= '0;
      perf_ld_cnt    <= '0;
    end else begin
      if (stall && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if ((state == RESP) && !req_write && (perf_ld_cnt != '1))
        perf_ld_cnt <= perf_ld_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_otter_mem_stage_ctrl.sv
// Self-checking bench for otter_mem_stage_ctrl: directed and randomized accesses against an arithmetic reference model.
module tb_otter_mem_stage_ctrl;

  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned LAT     = 2;
  localparam logic [31:0] IO_BASE = 32'h1100_0000;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              stall;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              misalign_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_we;
  logic              mem_re;
  logic [31:0]       mem_rdata;
  logic [31:0]       io_addr;
  logic [31:0]       io_wdata;
  logic              io_wr;
  logic [31:0]       io_in;
`ifdef MEM_PERF_CNT_EN
  logic [31:0]       perf_stall_cnt;
  logic [31:0]       perf_ld_cnt;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  otter_mem_stage_ctrl #(
    .ADDR_W (ADDR_W),
    .LATENCY(LAT),
    .IO_BASE(IO_BASE)
  ) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .misalign_err(misalign_err),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_rdata   (mem_rdata),
    .io_addr     (io_addr),
    .io_wdata    (io_wdata),
    .io_wr       (io_wr),
    .io_in       (io_in)
`ifdef MEM_PERF_CNT_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_ld_cnt   (perf_ld_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_misaligned(input logic [1:0] sz, input logic [31:0] addr);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1) return (addr % 2) != 0;
    if (sz == 2'd2) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] src, input logic [1:0] sz,
                                             input logic uns, input logic [31:0] addr);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (src >> (8 * (addr % 4))) & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      v = (src >> (8 * (addr & 32'd2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = src;
    end
    return v;
  endfunction

  function automatic int unsigned lane_base(input logic [1:0] sz, input logic [31:0] addr);
    if (sz == 2'd0) return addr % 4;
    if (sz == 2'd1) return addr & 32'd2;
    return 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] addr);
    if (sz == 2'd0) return 4'(1 << (addr % 4));
    if (sz == 2'd1) return 4'(3 << (addr & 32'd2));
    return 4'hF;
  endfunction

  // One complete access; gap=1 drops req_valid afterwards and checks the controller went quiet.
  task automatic do_access(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd_data, input bit gap, input string name);
    logic        mis, io, mem_load, exp_we, exp_re, exp_iow;
    int unsigned k_rsp, base;
    logic [31:0] exp_rdata, exp_w, mask;
    logic [3:0]  exp_be;
    logic [9:0]  act_v, exp_v;
    mis      = model_misaligned(sz, addr);
    io       = (addr >= IO_BASE);
    mem_load = !mis && !io && !wr;
    exp_we   = !mis && !io && wr;
    exp_re   = mem_load;
    exp_iow  = !mis && io && wr;
    k_rsp    = mem_load ? LAT + 1 : 1;
    exp_rdata = (mis || wr) ? 32'd0 : model_load(rd_data, sz, uns, addr);
    exp_be   = model_be(sz, addr);
    base     = lane_base(sz, addr);
    exp_w = '0;
    mask  = '0;
    for (int i = 0; i < 4; i++) begin
      if (exp_be[i]) begin
        exp_w[8*i +: 8] = wd[8*(i - int'(base)) +: 8];
        mask[8*i +: 8]  = 8'hFF;
      end
    end
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    io_in        = io ? rd_data : $urandom;
    mem_rdata    = $urandom;
    for (int unsigned k = 0; k <= k_rsp; k++) begin
      if (k > 0) begin
        @(negedge clk);
        mem_rdata = (mem_load && k == LAT) ? rd_data : $urandom;
        io_in     = $urandom;
      end
      #1;
      act_v = {stall, mem_re, mem_we, io_wr, rsp_valid, misalign_err, mem_be};
      exp_v = {(k < k_rsp), (k == 0) && exp_re, (k == 0) && exp_we, (k == 0) && exp_iow,
               (k == k_rsp), (k == k_rsp) && mis, ((k == 0) && exp_we) ? exp_be : 4'h0};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s ctrl cycle %0d: got {stall,re,we,iowr,rsp,err,be}=%b want %b", name, k, act_v, exp_v);
      end
      if (k == 0 && exp_re) begin
        checks++;
        if (mem_addr !== ADDR_W'((addr / 4) % (32'd1 << ADDR_W))) begin
          errors++;
          $display("FAIL %s mem_addr: got %h want %h", name, mem_addr, (addr / 4) % (32'd1 << ADDR_W));
        end
      end
      if (k == 0 && exp_we) begin
        checks++;
        if ((mem_wdata & mask) !== exp_w) begin
          errors++;
          $display("FAIL %s mem_wdata: got %h want %h on mask %h", name, mem_wdata, exp_w, mask);
        end
      end
      if (k == 0 && exp_iow) begin
        checks++;
        if (io_addr !== addr || io_wdata !== wd) begin
          errors++;
          $display("FAIL %s io bus: got addr %h data %h want %h %h", name, io_addr, io_wdata, addr, wd);
        end
      end
      if (k == k_rsp) begin
        checks++;
        if (rsp_rdata !== exp_rdata) begin
          errors++;
          $display("FAIL %s rsp_rdata: got %h want %h", name, rsp_rdata, exp_rdata);
        end
      end
    end
    if (gap) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      checks++;
      if ({stall, rsp_valid, mem_re, mem_we, io_wr} !== 5'b0) begin
        errors++;
        $display("FAIL %s after-resp idle: got {stall,rsp,re,we,iowr}=%b want 00000", name,
                 {stall, rsp_valid, mem_re, mem_we, io_wr});
      end
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    req_addr     = 32'h100;
    req_wdata    = '0;
    mem_rdata    = '0;
    io_in        = '0;
    repeat (2) @(negedge clk);
    req_valid = 1'b1;
    #1;
    checks++;
    if ({stall, mem_re, mem_we, io_wr, rsp_valid, misalign_err} !== 6'b100000 || rsp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset outputs: got {stall,re,we,iowr,rsp,err}=%b rdata=%h want 100000 rdata=0",
               {stall, mem_re, mem_we, io_wr, rsp_valid, misalign_err}, rsp_rdata);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({mem_re, rsp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset held over edge: got {re,rsp}=%b want 00", {mem_re, rsp_valid});
    end
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 1'b0;
`ifdef MEM_PERF_CNT_EN
    #1;
    checks++;
    if (perf_stall_cnt !== 32'd0 || perf_ld_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf after reset: got %0d/%0d want 0/0", perf_stall_cnt, perf_ld_cnt);
    end
`endif
    // First access after release is accepted at once (mem_re in its first cycle).
    do_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1, "first_load_word");
`ifdef MEM_PERF_CNT_EN
    checks++;
    if (perf_stall_cnt !== 32'd3 || perf_ld_cnt !== 32'd1) begin
      errors++;
      $display("FAIL perf after one load: got stall=%0d ld=%0d want 3/1", perf_stall_cnt, perf_ld_cnt);
    end
`endif
  endtask

  task automatic test_load_ext();
    do_access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF_FFFF, 1'b1, "load_byte_signed");
    do_access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF_FFFF, 1'b1, "load_byte_unsigned");
    do_access(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h80FF_FFFF, 1'b1, "load_half_signed");
    do_access(1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 32'h1234_F00D, 1'b1, "load_half_unsigned");
  endtask

  task automatic test_store();
    do_access(1'b1, 2'd1, 1'b0, 32'h206, 32'h1234_ABCD, 32'h0, 1'b1, "store_half");
    do_access(1'b1, 2'd0, 1'b0, 32'h201, 32'hA5A5_A55A, 32'h0, 1'b1, "store_byte");
    do_access(1'b1, 2'd2, 1'b0, 32'h208, 32'hCAFE_F00D, 32'h0, 1'b1, "store_word");
  endtask

  task automatic test_io();
    do_access(1'b1, 2'd2, 1'b0, 32'h1100_0004, 32'd5, 32'h0, 1'b1, "io_store");
    do_access(1'b0, 2'd2, 1'b0, 32'h1100_0000, 32'h0, 32'h7654_3210, 1'b1, "io_load_base");
    do_access(1'b0, 2'd2, 1'b0, 32'h10FF_FFFC, 32'h0, 32'h0BAD_F00D, 1'b1, "mem_below_io");
  endtask

  task automatic test_misalign();
    do_access(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'hFFFF_FFFF, 1'b1, "misalign_word");
    do_access(1'b1, 2'd1, 1'b0, 32'h203, 32'h1111_2222, 32'h0, 1'b1, "misalign_half_store");
    do_access(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h1234_5678, 1'b1, "illegal_size");
    do_access(1'b1, 2'd2, 1'b0, 32'h1100_0002, 32'h9, 32'h0, 1'b1, "misalign_io_store");
  endtask

  task automatic test_back_to_back();
    do_access(1'b1, 2'd2, 1'b0, 32'h300, 32'h1111_1111, 32'h0, 1'b0, "b2b_store_a");
    do_access(1'b1, 2'd0, 1'b0, 32'h302, 32'h0000_0077, 32'h0, 1'b0, "b2b_store_b");
    do_access(1'b0, 2'd2, 1'b0, 32'h304, 32'h0, 32'h5555_AAAA, 1'b0, "b2b_load");
    do_access(1'b0, 2'd0, 1'b0, 32'h305, 32'h0, 32'h0000_8000, 1'b1, "b2b_load_byte");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'd2;
    req_addr  = 32'h400;
    mem_rdata = 32'h1357_9BDF;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stall, mem_re, rsp_valid} !== 3'b100) begin
      errors++;
      $display("FAIL reset_mid during reset: got {stall,re,rsp}=%b want 100", {stall, mem_re, rsp_valid});
    end
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned k = 0; k < LAT + 3; k++) begin
      #1;
      checks++;
      if ({stall, rsp_valid, rsp_rdata} !== 34'd0) begin
        errors++;
        $display("FAIL reset_mid quiet cycle %0d: got stall=%b rsp=%b rdata=%h want 0 0 0", k, stall, rsp_valid, rsp_rdata);
      end
      @(negedge clk);
    end
`ifdef MEM_PERF_CNT_EN
    checks++;
    if (perf_stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf_stall after mid reset: got %0d want 0", perf_stall_cnt);
    end
`endif
    do_access(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'h2468_ACE0, 1'b1, "load_after_mid_reset");
  endtask

  task automatic test_random();
    logic        wr, uns;
    logic [1:0]  sz;
    logic [31:0] addr;
    int unsigned r;
    for (int n = 0; n < 80; n++) begin
      wr  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      r   = $urandom_range(0, 9);
      if (r < 6)       addr = $urandom & 32'h0000_FFFF;
      else if (r < 8)  addr = IO_BASE + ($urandom & 32'hFF);
      else if (r == 8) addr = IO_BASE - 32'd1 - $urandom_range(0, 7);
      else             addr = $urandom;
      do_access(wr, sz, uns, addr, $urandom, $urandom, bit'($urandom_range(0, 1)), "random");
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_ext();
    test_store();
    test_io();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
